mem_bus_controller: RTL and testbench
=====================================

Name: mem_bus_controller

Overview:
Two-master, single-slave memory bus controller in front of the MCU memory map. It arbitrates between the instruction-fetch port (M0, read-only) and the data port (M1, read/write), and decodes addr[31:16] into the BRAM, SRAM, flash and peripheral regions. It drives one shared slave bus with per-region wait states and returns ack/rdata or an error to the granted master.

Parameters:
BRAM_WAIT, 0, extra access cycles for region 16'h0000
SRAM_WAIT, 1, extra access cycles for region 16'h0001
FLASH_WAIT, 3, extra access cycles for region 16'h0002
PERIPH_WAIT, 1, extra access cycles for region 16'h0003
WAIT_W, 4, wait counter width; every *_WAIT must be at most 2^WAIT_W-1

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
m0_req  in  1  M0 read request; held until m0_ack or m0_err
m0_addr  in  32  M0 byte address
m0_ack  out  1  one-cycle pulse: M0 transfer complete
m0_err  out  1  one-cycle pulse: M0 transfer failed
m0_rdata  out  32  M0 read data, valid while m0_ack=1
m1_req  in  1  M1 request; held until m1_ack or m1_err
m1_we  in  1  M1 write enable
m1_addr  in  32  M1 byte address
m1_wdata  in  32  M1 write data
m1_be  in  4  M1 byte enables
m1_ack  out  1  one-cycle pulse: M1 transfer complete
m1_err  out  1  one-cycle pulse: M1 transfer failed
m1_rdata  out  32  M1 read data, valid while m1_ack=1
mem_en  out  1  slave access active
mem_we  out  1  slave write strobe
mem_addr  out  32  slave address
mem_wdata  out  32  slave write data
mem_be  out  4  slave byte enables
bram_sel  out  1  region select, 16'h0000
sram_sel  out  1  region select, 16'h0001
flash_sel  out  1  region select, 16'h0002
periph_sel  out  1  region select, 16'h0003
mem_rdata  in  32  slave read data, muxed externally by region

Behaviour:
- Reset (async, rst_n=0): state=IDLE; all outputs 0; wait counter 0; last_grant=M1, so M0 wins the first contest. Reset mid-transfer aborts it; no ack or err is issued for it.
- State IDLE:
  - If any req is high, grant one master: the sole requester, or on contention the master not in last_grant (round-robin).
  - Latch addr, we, wdata and be. For M0, we=0 and be=4'hF.
  - Update last_grant and decode addr[31:16].
  - Go to ERR if the region is unmapped (>16'h0003) or the access is a write to flash. Otherwise go to ACCESS and load the counter with that region's WAIT.
- State ACCESS:
  - mem_en=1; the selected region's sel=1; mem_addr, mem_we, mem_wdata and mem_be come from the latched values and stay stable throughout.
  - The counter decrements each cycle. In the cycle the counter==0, register mem_rdata and go to RESP.
  - Stays in ACCESS for WAIT+1 cycles. mem_we is high for that whole window; the slave commits on the final cycle.
- State RESP: granted master's ack=1 for one cycle with rdata (0 for writes); all mem_* and sel outputs are 0; go to IDLE.
- State ERR: granted master's err=1 for one cycle; rdata=0; no slave access occurs (mem_en and sel stay 0); go to IDLE.
- Latency from req sampled in IDLE (cycle 0) to ack: WAIT+2 cycles. Err arrives in cycle 1.
- Selects are one-hot or all-zero; at most one is high, and only while mem_en=1.
- Master rule: req must be low in the cycle after ack/err unless a new transfer is intended. A req still high in IDLE is a new request.
- The ungranted master's req is ignored until the controller returns to IDLE. Its ack, err and rdata stay 0.
- Addresses pass through unmodified; there is no alignment check.

Decomposition:
- Shared package mem_map_pkg holds:
  - region constants REGION_BRAM=16'h0000, REGION_SRAM=16'h0001, REGION_FLASH=16'h0002, REGION_PERIPH=16'h0003
  - the state encoding IDLE/ACCESS/RESP/ERR
  - master IDs M0=0, M1=1
- One natural sub-module: rr_arbiter2, a 2-input round-robin grant with a last_grant register.
- Region decode is an inline combinational case.

Test Plan:
- Reset release, then M0 reads 0x0000_0010 with mem_rdata=0xDEADBEEF -> bram_sel=1 and mem_en=1 for 1 cycle; m0_ack in cycle 2 with m0_rdata=0xDEADBEEF.
- M1 writes 0x0001_0004, wdata=0x12345678, be=4'b0011 -> sram_sel, mem_we=1 and mem_be=4'b0011 for 2 cycles; m1_ack in cycle 3; m0 outputs stay 0.
- M0 and M1 both request in the same cycle after reset -> M0 granted first. When both re-request together, M1 is granted; grants alternate M0, M1, M0.
- M1 writes 0x0002_0000 -> m1_err in cycle 1; mem_en and flash_sel never assert. M0 reads 0x0002_0000 -> flash_sel held 4 cycles, ack in cycle 5.
- M0 reads 0x0004_0000 -> m0_err in cycle 1; no select asserts; the next M0 read of 0x0003_0000 completes normally with periph_sel held 2 cycles.
- rst_n driven low during a FLASH ACCESS cycle -> all outputs 0 immediately; no ack or err after release; the next M0 read proceeds from IDLE.

Source files
------------

// File: rtl/mem_map_pkg.sv
// Shared memory-map constants, controller state encoding and master IDs
// for the two-master memory bus controller.
package mem_map_pkg;

    localparam logic [15:0] REGION_BRAM   = 16'h0000;
    localparam logic [15:0] REGION_SRAM   = 16'h0001;
    localparam logic [15:0] REGION_FLASH  = 16'h0002;
    localparam logic [15:0] REGION_PERIPH = 16'h0003;

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] ACCESS = 2'd1;
    localparam logic [1:0] RESP   = 2'd2;
    localparam logic [1:0] ERR    = 2'd3;

    localparam logic M0 = 1'b0;
    localparam logic M1 = 1'b1;

    typedef struct packed {
        logic [31:0] addr;
        logic        we;
        logic [31:0] wdata;
        logic [3:0]  be;
    } bus_req_t;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-input round-robin arbiter: on contention the master that did not win
// last time is granted; last_grant only moves when the caller commits a grant.
module rr_arbiter2
    import mem_map_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req_i,
    input  logic       update_i,
    output logic       grant_o
);

    logic last_q;

    always_comb begin
        if (req_i[0] && req_i[1]) begin
            grant_o = ~last_q;
        end else begin
            grant_o = req_i[1];
        end
    end

    // Reset to M1 so that M0 wins the first contest.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_q <= M1;
        end else if (update_i) begin
            last_q <= grant_o;
        end
    end

endmodule

// File: rtl/mem_bus_controller.sv
// Arbitrates the fetch (M0) and data (M1) masters onto one slave bus, decodes
// the 64 KiB regions and applies per-region wait states.
module mem_bus_controller
    import mem_map_pkg::*;
#(
    parameter int BRAM_WAIT   = 0,
    parameter int SRAM_WAIT   = 1,
    parameter int FLASH_WAIT  = 3,
    parameter int PERIPH_WAIT = 1,
    parameter int WAIT_W      = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        m0_req,
    input  logic [31:0] m0_addr,
    output logic        m0_ack,
    output logic        m0_err,
    output logic [31:0] m0_rdata,
    input  logic        m1_req,
    input  logic        m1_we,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    input  logic [3:0]  m1_be,
    output logic        m1_ack,
    output logic        m1_err,
    output logic [31:0] m1_rdata,
    output logic        mem_en,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_be,
    output logic        bram_sel,
    output logic        sram_sel,
    output logic        flash_sel,
    output logic        periph_sel,
    input  logic [31:0] mem_rdata
);

    logic [1:0]        state_q, state_d;
    logic [WAIT_W-1:0] cnt_q, cnt_d;
    logic              gnt_q, gnt_d;
    bus_req_t          req_q, req_d;
    logic [3:0]        sel_q, sel_d;
    logic [31:0]       rdata_q, rdata_d;

    logic              any_req;
    logic              arb_update;
    logic              arb_grant;
    bus_req_t          req_cur;
    logic [3:0]        dec_sel;
    logic [WAIT_W-1:0] dec_wait;
    logic              dec_err;

    assign any_req    = m0_req | m1_req;
    assign arb_update = (state_q == IDLE) && any_req;

    rr_arbiter2 u_arb (
        .clk      (clk),
        .rst_n    (rst_n),
        .req_i    ({m1_req, m0_req}),
        .update_i (arb_update),
        .grant_o  (arb_grant)
    );

    // The fetch port is read-only with full-word enables.
    always_comb begin
        if (arb_grant == M1) begin
            req_cur.addr  = m1_addr;
            req_cur.we    = m1_we;
            req_cur.wdata = m1_wdata;
            req_cur.be    = m1_be;
        end else begin
            req_cur.addr  = m0_addr;
            req_cur.we    = 1'b0;
            req_cur.wdata = '0;
            req_cur.be    = 4'hF;
        end
    end

    always_comb begin
        dec_sel  = 4'b0000;
        dec_wait = '0;
        case (req_cur.addr[31:16])
            REGION_BRAM: begin
                dec_sel  = 4'b0001;
                dec_wait = WAIT_W'(BRAM_WAIT);
            end
            REGION_SRAM: begin
                dec_sel  = 4'b0010;
                dec_wait = WAIT_W'(SRAM_WAIT);
            end
            REGION_FLASH: begin
                dec_sel  = 4'b0100;
                dec_wait = WAIT_W'(FLASH_WAIT);
            end
            REGION_PERIPH: begin
                dec_sel  = 4'b1000;
                dec_wait = WAIT_W'(PERIPH_WAIT);
            end
            default: begin
                dec_sel  = 4'b0000;
                dec_wait = '0;
            end
        endcase
        dec_err = (dec_sel == 4'b0000) || (req_cur.we && dec_sel[2]);
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        gnt_d   = gnt_q;
        req_d   = req_q;
        sel_d   = sel_q;
        rdata_d = rdata_q;
        case (state_q)
            IDLE: begin
                if (any_req) begin
                    gnt_d = arb_grant;
                    req_d = req_cur;
                    sel_d = dec_sel;
                    cnt_d = dec_wait;
                    state_d = dec_err ? ERR : ACCESS;
                end
            end
            ACCESS: begin
                // Read data is captured in the final wait cycle; writes return zero.
                if (cnt_q == '0) begin
                    rdata_d = req_q.we ? '0 : mem_rdata;
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - WAIT_W'(1);
                end
            end
            RESP:    state_d = IDLE;
            ERR:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            gnt_q   <= M0;
            req_q   <= '0;
            sel_q   <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            gnt_q   <= gnt_d;
            req_q   <= req_d;
            sel_q   <= sel_d;
            rdata_q <= rdata_d;
        end
    end

    logic in_access;
    logic in_resp;
    logic in_err;

    assign in_access = (state_q == ACCESS);
    assign in_resp   = (state_q == RESP);
    assign in_err    = (state_q == ERR);

    // Slave-side signals are only driven during the access window.
    assign mem_en     = in_access;
    assign mem_we     = in_access & req_q.we;
    assign mem_addr   = in_access ? req_q.addr  : '0;
    assign mem_wdata  = in_access ? req_q.wdata : '0;
    assign mem_be     = in_access ? req_q.be    : '0;
    assign bram_sel   = in_access & sel_q[0];
    assign sram_sel   = in_access & sel_q[1];
    assign flash_sel  = in_access & sel_q[2];
    assign periph_sel = in_access & sel_q[3];

    assign m0_ack   = in_resp & (gnt_q == M0);
    assign m0_err   = in_err  & (gnt_q == M0);
    assign m0_rdata = (in_resp && gnt_q == M0) ? rdata_q : '0;
    assign m1_ack   = in_resp & (gnt_q == M1);
    assign m1_err   = in_err  & (gnt_q == M1);
    assign m1_rdata = (in_resp && gnt_q == M1) ? rdata_q : '0;

endmodule

// File: tb/tb_mem_bus_controller.sv
// Bench for mem_bus_controller: a transaction-schedule model predicts every
// output cycle by cycle, plus directed transfers with hand-computed results.
module tb_mem_bus_controller;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        m0_req = 1'b0;
    logic [31:0] m0_addr = '0;
    logic        m1_req = 1'b0;
    logic        m1_we = 1'b0;
    logic [31:0] m1_addr = '0;
    logic [31:0] m1_wdata = '0;
    logic [3:0]  m1_be = '0;
    logic [31:0] mem_rdata = '0;
    logic        m0_ack, m0_err, m1_ack, m1_err;
    logic [31:0] m0_rdata, m1_rdata;
    logic        mem_en, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_be;
    logic        bram_sel, sram_sel, flash_sel, periph_sel;

    always #5 clk = ~clk;

    mem_bus_controller dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .m0_req     (m0_req),
        .m0_addr    (m0_addr),
        .m0_ack     (m0_ack),
        .m0_err     (m0_err),
        .m0_rdata   (m0_rdata),
        .m1_req     (m1_req),
        .m1_we      (m1_we),
        .m1_addr    (m1_addr),
        .m1_wdata   (m1_wdata),
        .m1_be      (m1_be),
        .m1_ack     (m1_ack),
        .m1_err     (m1_err),
        .m1_rdata   (m1_rdata),
        .mem_en     (mem_en),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_be     (mem_be),
        .bram_sel   (bram_sel),
        .sram_sel   (sram_sel),
        .flash_sel  (flash_sel),
        .periph_sel (periph_sel),
        .mem_rdata  (mem_rdata)
    );

    typedef struct packed {
        logic        en;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic [3:0]  sel;
        logic        ack0;
        logic        ack1;
        logic        err0;
        logic        err1;
        logic        rd;
    } exp_t;

    exp_t        ring [64];
    logic [31:0] rdh  [64];
    int          cyc = 0;
    int          free_c = 0;
    int          n_chk = 0;
    int          n_fail = 0;
    logic        last_g = 1'b1;
    logic        dn0 = 1'b0;
    logic        dn1 = 1'b0;

    function automatic int wait_of(input logic [15:0] r);
        case (r)
            16'h0000: return 0;
            16'h0001: return 1;
            16'h0002: return 3;
            16'h0003: return 1;
            default:  return 0;
        endcase
    endfunction

    function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, req, cyc);
        end
    endfunction

    function automatic logic [31:0] rand_addr();
        logic [15:0] hi;
        case ($urandom_range(0, 5))
            0:       hi = 16'h0000;
            1:       hi = 16'h0001;
            2:       hi = 16'h0002;
            3:       hi = 16'h0003;
            4:       hi = 16'h0004;
            default: hi = 16'($urandom);
        endcase
        return {hi, 16'($urandom)};
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Compare DUT against the schedule, then let the model react to this cycle's requests.
    always @(negedge clk) begin : compare
        exp_t        e;
        logic [31:0] exp_rd;
        logic [31:0] exp_ctrl;
        logic [31:0] act_ctrl;
        logic        g;
        logic        w;
        logic [31:0] a;
        logic [15:0] rg;
        int          wt;
        int          idx;
        if (!rst_n) begin
            for (int i = 0; i < 64; i++) ring[i] = '0;
            free_c = 0;
            last_g = 1'b1;
        end
        idx = cyc % 64;
        e = ring[idx];
        exp_rd = e.rd ? rdh[(cyc + 63) % 64] : 32'h0;
        exp_ctrl = {18'b0, e.ack0, e.err0, e.ack1, e.err1, e.en, e.we, e.sel, e.be};
        act_ctrl = {18'b0, m0_ack, m0_err, m1_ack, m1_err, mem_en, mem_we,
                    periph_sel, flash_sel, sram_sel, bram_sel, mem_be};
        chk("ctrl", act_ctrl, exp_ctrl);
        chk("mem_addr", mem_addr, e.addr);
        chk("mem_wdata", mem_wdata, e.wdata);
        chk("m0_rdata", m0_rdata, e.ack0 ? exp_rd : 32'h0);
        chk("m1_rdata", m1_rdata, e.ack1 ? exp_rd : 32'h0);
        ring[idx] = '0;
        rdh[idx] = mem_rdata;
        dn0 = m0_ack | m0_err;
        dn1 = m1_ack | m1_err;
        if (rst_n && cyc >= free_c && (m0_req || m1_req)) begin
            g = (m0_req && m1_req) ? ~last_g : m1_req;
            last_g = g;
            a = g ? m1_addr : m0_addr;
            w = g ? m1_we : 1'b0;
            rg = a[31:16];
            if (rg > 16'h0003 || (w && rg == 16'h0002)) begin
                idx = (cyc + 1) % 64;
                ring[idx].err0 = ~g;
                ring[idx].err1 = g;
                free_c = cyc + 2;
            end else begin
                wt = wait_of(rg);
                for (int t = 1; t <= wt + 1; t++) begin
                    idx = (cyc + t) % 64;
                    ring[idx].en    = 1'b1;
                    ring[idx].we    = w;
                    ring[idx].addr  = a;
                    ring[idx].wdata = g ? m1_wdata : 32'h0;
                    ring[idx].be    = g ? m1_be : 4'hF;
                    ring[idx].sel   = 4'b0001 << rg[1:0];
                end
                idx = (cyc + wt + 2) % 64;
                ring[idx].ack0 = ~g;
                ring[idx].ack1 = g;
                ring[idx].rd   = ~w;
                free_c = cyc + wt + 3;
            end
        end
    end

    int          r_lat, r_en, r_we, r_sel_n, r_other;
    logic [3:0]  r_sel_or, r_be_or;
    logic [31:0] r_rd;
    logic        r_err;

    task automatic run_req(input logic mst, input logic we, input logic [31:0] addr,
                           input logic [31:0] wd, input logic [3:0] be);
        logic [3:0] sel;
        logic       done;
        r_lat = -1; r_en = 0; r_we = 0; r_sel_n = 0; r_other = 0;
        r_sel_or = '0; r_be_or = '0; r_rd = '0; r_err = 1'b0;
        @(posedge clk); #1;
        if (mst) begin
            m1_req = 1'b1; m1_we = we; m1_addr = addr; m1_wdata = wd; m1_be = be;
        end else begin
            m0_req = 1'b1; m0_addr = addr;
        end
        for (int t = 0; t < 20; t++) begin
            @(negedge clk);
            sel = {periph_sel, flash_sel, sram_sel, bram_sel};
            r_en    += int'(mem_en);
            r_we    += int'(mem_we);
            r_sel_n += int'(|sel);
            r_sel_or |= sel;
            if (mem_en) r_be_or |= mem_be;
            if (mst) r_other += int'(m0_ack | m0_err | (|m0_rdata));
            else     r_other += int'(m1_ack | m1_err | (|m1_rdata));
            done = mst ? (m1_ack | m1_err) : (m0_ack | m0_err);
            if (done) begin
                r_lat = t;
                r_err = mst ? m1_err : m0_err;
                r_rd  = mst ? m1_rdata : m0_rdata;
                break;
            end
        end
        @(posedge clk); #1;
        m0_req = 1'b0;
        m1_req = 1'b0;
    endtask

    initial begin
        logic [3:0] ord;
        int         n;
        int         cnt;
        logic       b0;
        logic       b1;

        repeat (3) @(negedge clk);
        chk("reset_ctrl", {18'b0, m0_ack, m0_err, m1_ack, m1_err, mem_en, mem_we,
                           periph_sel, flash_sel, sram_sel, bram_sel, mem_be}, 32'h0);
        chk("reset_addr", mem_addr, 32'h0);
        #2 rst_n = 1'b1;
        mem_rdata = 32'hDEAD_BEEF;

        run_req(1'b0, 1'b0, 32'h0000_0010, 32'h0, 4'h0);
        chk("bram_rd_lat", r_lat, 2);
        chk("bram_rd_data", r_rd, 32'hDEAD_BEEF);
        chk("bram_rd_en_cycles", r_en, 1);
        chk("bram_rd_sel", {28'b0, r_sel_or}, 32'h1);

        run_req(1'b1, 1'b1, 32'h0001_0004, 32'h1234_5678, 4'b0011);
        chk("sram_wr_lat", r_lat, 3);
        chk("sram_wr_we_cycles", r_we, 2);
        chk("sram_wr_be", {28'b0, r_be_or}, 32'h3);
        chk("sram_wr_sel", {28'b0, r_sel_or}, 32'h2);
        chk("sram_wr_m0_quiet", r_other, 0);
        chk("sram_wr_rdata", r_rd, 32'h0);

        // Both masters hold req continuously: grants must alternate M0, M1, M0, M1.
        @(posedge clk); #1;
        m0_addr = 32'h0000_0100; m1_addr = 32'h0000_0200; m1_we = 1'b0;
        m0_req = 1'b1; m1_req = 1'b1;
        ord = '0; n = 0;
        for (int t = 0; t < 40 && n < 4; t++) begin
            @(negedge clk);
            if (m0_ack) begin ord = {ord[2:0], 1'b0}; n++; end
            if (m1_ack) begin ord = {ord[2:0], 1'b1}; n++; end
        end
        @(posedge clk); #1;
        m0_req = 1'b0; m1_req = 1'b0;
        chk("grant_count", n, 4);
        chk("grant_order", {28'b0, ord}, 32'h5);

        run_req(1'b1, 1'b1, 32'h0002_0000, 32'hCAFE_F00D, 4'hF);
        chk("flash_wr_lat", r_lat, 1);
        chk("flash_wr_err", {31'b0, r_err}, 32'h1);
        chk("flash_wr_en_cycles", r_en, 0);
        chk("flash_wr_sel", {28'b0, r_sel_or}, 32'h0);

        run_req(1'b0, 1'b0, 32'h0002_0000, 32'h0, 4'h0);
        chk("flash_rd_lat", r_lat, 5);
        chk("flash_rd_sel_cycles", r_sel_n, 4);
        chk("flash_rd_data", r_rd, 32'hDEAD_BEEF);

        run_req(1'b0, 1'b0, 32'h0004_0000, 32'h0, 4'h0);
        chk("unmapped_lat", r_lat, 1);
        chk("unmapped_err", {31'b0, r_err}, 32'h1);
        chk("unmapped_sel", {28'b0, r_sel_or}, 32'h0);
        chk("unmapped_rdata", r_rd, 32'h0);

        run_req(1'b0, 1'b0, 32'h0003_0000, 32'h0, 4'h0);
        chk("periph_lat", r_lat, 3);
        chk("periph_sel_cycles", r_sel_n, 2);
        chk("periph_sel", {28'b0, r_sel_or}, 32'h8);

        // Reset in the middle of a flash access must abort it silently.
        @(posedge clk); #1;
        m0_addr = 32'h0002_0000; m0_req = 1'b1;
        repeat (2) @(negedge clk);
        @(posedge clk); #3;
        rst_n = 1'b0; m0_req = 1'b0;
        #1;
        chk("rst_mid_ctrl", {18'b0, m0_ack, m0_err, m1_ack, m1_err, mem_en, mem_we,
                             periph_sel, flash_sel, sram_sel, bram_sel, mem_be}, 32'h0);
        chk("rst_mid_addr", mem_addr, 32'h0);
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;
        cnt = 0;
        repeat (8) begin
            @(negedge clk);
            cnt += int'(m0_ack | m0_err | m1_ack | m1_err);
        end
        chk("no_resp_after_rst", cnt, 0);
        run_req(1'b0, 1'b0, 32'h0000_0040, 32'h0, 4'h0);
        chk("post_rst_lat", r_lat, 2);

        // Randomised traffic from both masters, checked by the schedule model.
        b0 = 1'b0; b1 = 1'b0;
        for (int k = 0; k < 4000; k++) begin
            @(posedge clk); #1;
            mem_rdata = $urandom;
            if (b0 && dn0) b0 = 1'b0;
            if (b1 && dn1) b1 = 1'b0;
            if (!b0) begin
                if ($urandom_range(0, 2) == 0) begin
                    m0_addr = rand_addr(); m0_req = 1'b1; b0 = 1'b1;
                end else begin
                    m0_req = 1'b0;
                end
            end
            if (!b1) begin
                if ($urandom_range(0, 2) == 0) begin
                    m1_addr = rand_addr(); m1_we = 1'($urandom);
                    m1_wdata = $urandom; m1_be = 4'($urandom);
                    m1_req = 1'b1; b1 = 1'b1;
                end else begin
                    m1_req = 1'b0;
                end
            end
        end
        for (int k = 0; k < 60 && (b0 || b1); k++) begin
            @(posedge clk); #1;
            if (b0 && dn0) begin b0 = 1'b0; m0_req = 1'b0; end
            if (b1 && dn1) begin b1 = 1'b0; m1_req = 1'b0; end
        end
        chk("drain_busy", {30'b0, b1, b0}, 32'h0);
        m0_req = 1'b0; m1_req = 1'b0;
        repeat (4) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
